// File: rtl/csr_hpm.sv
// Machine counter CSR block: mcycle, minstret, NHPM event counters with
// per-counter event select, overflow flag/interrupt enable, and mcountinhibit.
module csr_hpm #(
  parameter int unsigned NHPM  = 4,
  parameter int unsigned NEVT  = 8,
  parameter int unsigned CNT_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            crden,
  input  logic [11:0]     craddr,
  output logic [31:0]     cdata,
  input  logic            cwren,
  input  logic [11:0]     cwaddr,
  input  logic [31:0]     cwdata,
  input  logic            retire,
  input  logic [NEVT-1:0] events,
  output logic            ovf_irq
);

  // Writable inhibit bits: CY, IR and one per implemented hpm counter.
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NHPM) - 32'h1) << 3);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;
  logic [CNT_W-1:0] hpm_q [NHPM];
  logic [CNT_W-1:0] hpm_d [NHPM];
  logic [7:0]       sel_q [NHPM];
  logic [7:0]       sel_d [NHPM];
  logic [NHPM-1:0]  ofie_q, ofie_d;
  logic [NHPM-1:0]  of_q, of_d;
  logic [31:0]      inh_q, inh_d;
  logic [255:0]     evt_pad;

  assign evt_pad = 256'(events);

  // Counters are handled through a 64-bit view so bits at or above CNT_W
  // read as zero and high-half writes drop them without width special cases.
  function automatic logic [CNT_W-1:0] put_half(input logic [CNT_W-1:0] cur,
                                                input logic hi,
                                                input logic [31:0] d);
    logic [63:0] e;
    e = 64'(cur);
    if (hi) e[63:32] = d;
    else    e[31:0]  = d;
    return e[CNT_W-1:0];
  endfunction

  function automatic logic [31:0] get_half(input logic [CNT_W-1:0] cur,
                                           input logic hi);
    logic [63:0] e;
    e = 64'(cur);
    return hi ? e[63:32] : e[31:0];
  endfunction

  always_comb begin : next_state
    cyc_d  = cyc_q;
    ins_d  = ins_q;
    inh_d  = inh_q;
    ofie_d = ofie_q;
    of_d   = of_q;
    for (int unsigned i = 0; i < NHPM; i++) begin
      hpm_d[i] = hpm_q[i];
      sel_d[i] = sel_q[i];
    end

    if (cwren && cwaddr == 12'hB00)      cyc_d = put_half(cyc_q, 1'b0, cwdata);
    else if (cwren && cwaddr == 12'hB80) cyc_d = put_half(cyc_q, 1'b1, cwdata);
    else if (!inh_q[0])                  cyc_d = cyc_q + ONE;

    if (cwren && cwaddr == 12'hB02)      ins_d = put_half(ins_q, 1'b0, cwdata);
    else if (cwren && cwaddr == 12'hB82) ins_d = put_half(ins_q, 1'b1, cwdata);
    else if (retire && !inh_q[2])        ins_d = ins_q + ONE;

    if (cwren && cwaddr == 12'h320) inh_d = cwdata & INH_MASK;

    for (int unsigned i = 0; i < NHPM; i++) begin : hpm_next
      logic hit;
      hit = (sel_q[i] != 8'd0) && ({24'd0, sel_q[i]} <= NEVT) &&
            evt_pad[sel_q[i] - 8'd1] && !inh_q[3+i];
      if (cwren && cwaddr == 12'(32'hB03 + i))
        hpm_d[i] = put_half(hpm_q[i], 1'b0, cwdata);
      else if (cwren && cwaddr == 12'(32'hB83 + i))
        hpm_d[i] = put_half(hpm_q[i], 1'b1, cwdata);
      else if (hit) begin
        hpm_d[i] = hpm_q[i] + ONE;
        if (&hpm_q[i]) of_d[i] = 1'b1;
      end
      // Software write to the event register overrides a same-cycle OF set.
      if (cwren && cwaddr == 12'(32'h323 + i)) begin
        sel_d[i]  = cwdata[7:0];
        ofie_d[i] = cwdata[30];
        of_d[i]   = cwdata[31];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q   <= '0;
      ins_q   <= '0;
      inh_q   <= '0;
      ofie_q  <= '0;
      of_q    <= '0;
      ovf_irq <= 1'b0;
      for (int unsigned i = 0; i < NHPM; i++) begin
        hpm_q[i] <= '0;
        sel_q[i] <= '0;
      end
    end else begin
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
      inh_q   <= inh_d;
      ofie_q  <= ofie_d;
      of_q    <= of_d;
      ovf_irq <= |(of_q & ofie_q);
      for (int unsigned i = 0; i < NHPM; i++) begin
        hpm_q[i] <= hpm_d[i];
        sel_q[i] <= sel_d[i];
      end
    end
  end

  always_comb begin : read_mux
    cdata = '0;
    if (crden) begin
      case (craddr)
        12'hB00: cdata = get_half(cyc_q, 1'b0);
        12'hB80: cdata = get_half(cyc_q, 1'b1);
        12'hB02: cdata = get_half(ins_q, 1'b0);
        12'hB82: cdata = get_half(ins_q, 1'b1);
        12'h320: cdata = inh_q;
        default: ;
      endcase
      for (int unsigned i = 0; i < NHPM; i++) begin
        if (craddr == 12'(32'hB03 + i)) cdata = get_half(hpm_q[i], 1'b0);
        if (craddr == 12'(32'hB83 + i)) cdata = get_half(hpm_q[i], 1'b1);
        if (craddr == 12'(32'h323 + i)) cdata = {of_q[i], ofie_q[i], 22'd0, sel_q[i]};
      end
    end
  end

endmodule

// File: tb/tb_csr_hpm.sv
// Directed and randomized checks of csr_hpm against an arithmetic model of
// the counter CSRs (40-bit counters, 4 hpm counters, 8 events).
module tb_csr_hpm;

  localparam int unsigned NH = 4;
  localparam int unsigned NE = 8;
  localparam int unsigned CW = 40;
  localparam longint unsigned MASK = (64'd1 << CW) - 64'd1;
  localparam bit [31:0] INH_W = 32'h0000_007D;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          crden = 1'b0;
  logic [11:0]   craddr = '0;
  logic [31:0]   cdata;
  logic          cwren = 1'b0;
  logic [11:0]   cwaddr = '0;
  logic [31:0]   cwdata = '0;
  logic          retire = 1'b0;
  logic [NE-1:0] events = '0;
  logic          ovf_irq;

  int checks = 0;
  int failures = 0;

  csr_hpm #(.NHPM(NH), .NEVT(NE), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .crden(crden), .craddr(craddr), .cdata(cdata),
    .cwren(cwren), .cwaddr(cwaddr), .cwdata(cwdata), .retire(retire),
    .events(events), .ovf_irq(ovf_irq)
  );

  always #50 clk = ~clk;

  longint unsigned m_cyc, m_ins, n_cyc, n_ins;
  longint unsigned m_hpm [NH];
  longint unsigned n_hpm [NH];
  bit [7:0]  m_sel [NH];
  bit [7:0]  n_sel [NH];
  bit [NH-1:0] m_ofie, m_of, n_ofie, n_of;
  bit [31:0] m_inh, n_inh;
  bit        m_irq, n_irq;

  bit [11:0] RD_ADDRS [20] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83,
                               12'hB04, 12'hB84, 12'hB05, 12'hB85, 12'hB06, 12'hB86,
                               12'h320, 12'h323, 12'h324, 12'h325, 12'h326, 12'hB01,
                               12'h327, 12'hB07};
  bit [11:0] WR_ADDRS [16] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83,
                               12'hB06, 12'hB86, 12'h323, 12'h326, 12'h320, 12'hB01,
                               12'h327, 12'hB07, 12'hB87, 12'h321};

  function automatic longint unsigned put_lo(longint unsigned v, bit [31:0] d);
    return ((v & 64'hFFFF_FFFF_0000_0000) | 64'(d)) & MASK;
  endfunction

  function automatic longint unsigned put_hi(longint unsigned v, bit [31:0] d);
    return ((v & 64'h0000_0000_FFFF_FFFF) | (64'(d) << 32)) & MASK;
  endfunction

  function automatic bit [31:0] exp_rd(bit [11:0] a);
    bit [31:0] r;
    r = '0;
    if (a == 12'hB00) r = m_cyc[31:0];
    if (a == 12'hB80) r = m_cyc[63:32];
    if (a == 12'hB02) r = m_ins[31:0];
    if (a == 12'hB82) r = m_ins[63:32];
    if (a == 12'h320) r = m_inh;
    for (int unsigned i = 0; i < NH; i++) begin
      if (a == 12'(12'hB03 + i)) r = m_hpm[i][31:0];
      if (a == 12'(12'hB83 + i)) r = m_hpm[i][63:32];
      if (a == 12'(12'h323 + i)) r = {m_of[i], m_ofie[i], 22'd0, m_sel[i]};
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_ins = 0; m_inh = '0; m_ofie = '0; m_of = '0; m_irq = 1'b0;
    for (int unsigned i = 0; i < NH; i++) begin
      m_hpm[i] = 0;
      m_sel[i] = '0;
    end
  endtask

  task automatic model_step();
    n_irq = |(m_of & m_ofie);
    n_cyc = m_cyc; n_ins = m_ins; n_inh = m_inh; n_ofie = m_ofie; n_of = m_of;
    if (cwren && cwaddr == 12'hB00)      n_cyc = put_lo(m_cyc, cwdata);
    else if (cwren && cwaddr == 12'hB80) n_cyc = put_hi(m_cyc, cwdata);
    else if (!m_inh[0])                  n_cyc = (m_cyc + 1) & MASK;
    if (cwren && cwaddr == 12'hB02)      n_ins = put_lo(m_ins, cwdata);
    else if (cwren && cwaddr == 12'hB82) n_ins = put_hi(m_ins, cwdata);
    else if (retire && !m_inh[2])        n_ins = (m_ins + 1) & MASK;
    if (cwren && cwaddr == 12'h320) n_inh = cwdata & INH_W;
    for (int unsigned i = 0; i < NH; i++) begin
      int s;
      bit hit;
      s = int'(m_sel[i]);
      hit = (s >= 1) && (s <= int'(NE)) && (events[s-1] == 1'b1) && !m_inh[3+i];
      n_hpm[i] = m_hpm[i];
      n_sel[i] = m_sel[i];
      if (cwren && cwaddr == 12'(12'hB03 + i))      n_hpm[i] = put_lo(m_hpm[i], cwdata);
      else if (cwren && cwaddr == 12'(12'hB83 + i)) n_hpm[i] = put_hi(m_hpm[i], cwdata);
      else if (hit) begin
        if (m_hpm[i] == MASK) begin
          n_hpm[i] = 0;
          n_of[i] = 1'b1;
        end else n_hpm[i] = m_hpm[i] + 1;
      end
      if (cwren && cwaddr == 12'(12'h323 + i)) begin
        n_sel[i] = cwdata[7:0];
        n_ofie[i] = cwdata[30];
        n_of[i] = cwdata[31];
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    m_cyc = n_cyc; m_ins = n_ins; m_inh = n_inh; m_ofie = n_ofie; m_of = n_of; m_irq = n_irq;
    for (int unsigned i = 0; i < NH; i++) begin
      m_hpm[i] = n_hpm[i];
      m_sel[i] = n_sel[i];
    end
  endtask

  task automatic wr(bit [11:0] a, bit [31:0] d);
    cwren = 1'b1; cwaddr = a; cwdata = d;
    cycle();
    cwren = 1'b0;
  endtask

  task automatic rd_chk(string tag, bit [11:0] a, bit [31:0] exp);
    crden = 1'b1; craddr = a;
    #1;
    chk(tag, cdata, exp);
  endtask

  task automatic check_all(string ph);
    crden = 1'b1;
    foreach (RD_ADDRS[k]) begin
      craddr = RD_ADDRS[k];
      #1;
      chk($sformatf("%s rd %h", ph, RD_ADDRS[k]), cdata, exp_rd(RD_ADDRS[k]));
    end
    chk({ph, " ovf_irq"}, {31'd0, ovf_irq}, {31'd0, m_irq});
  endtask

  initial begin
    longint unsigned s_cyc, s_ins;
    model_reset();
    #20;
    check_all("in_reset");
    @(negedge clk);
    rst = 1'b1;

    repeat (10) cycle();
    rd_chk("mcycle_after_10", 12'hB00, 32'd10);
    rd_chk("minstret_idle", 12'hB02, 32'd0);
    check_all("idle");

    crden = 1'b0; craddr = 12'hB00; #1;
    chk("crden_low", cdata, 32'd0);

    wr(12'hB00, 32'h100);
    rd_chk("mcycle_written", 12'hB00, 32'h100);
    cycle();
    rd_chk("mcycle_next", 12'hB00, 32'h101);

    wr(12'h320, 32'h5);
    s_cyc = m_cyc; s_ins = m_ins;
    retire = 1'b1;
    repeat (4) cycle();
    retire = 1'b0;
    rd_chk("inhibit_cyc", 12'hB00, s_cyc[31:0]);
    rd_chk("inhibit_ins", 12'hB02, s_ins[31:0]);
    rd_chk("inhibit_rd", 12'h320, 32'h5);
    wr(12'h320, 32'h0);
    retire = 1'b1;
    cycle();
    retire = 1'b0;
    rd_chk("resume_cyc", 12'hB00, 32'(s_cyc + 1));
    rd_chk("resume_ins", 12'hB02, 32'(s_ins + 1));
    check_all("inhibit");

    wr(12'h323, 32'h2);
    events = 8'b0000_0010;
    repeat (5) cycle();
    events = 8'b0000_0001;
    repeat (3) cycle();
    events = '0;
    rd_chk("hpm3_sel2", 12'hB03, 32'd5);
    check_all("select");

    wr(12'hB83, 32'hFF);
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'h323, 32'h4000_0001);
    rd_chk("hpm3_hi_max", 12'hB83, 32'hFF);
    events = 8'b0000_0001;
    cycle();
    events = '0;
    rd_chk("wrap_lo", 12'hB03, 32'd0);
    rd_chk("wrap_hi", 12'hB83, 32'd0);
    rd_chk("of_set", 12'h323, 32'hC000_0001);
    chk("irq_not_yet", {31'd0, ovf_irq}, 32'd0);
    cycle();
    chk("irq_next", {31'd0, ovf_irq}, 32'd1);

    wr(12'hB83, 32'hFF);
    wr(12'hB03, 32'hFFFF_FFFF);
    events = 8'b0000_0001;
    wr(12'h323, 32'h4000_0001);
    events = '0;
    rd_chk("sw_over_hw_of", 12'h323, 32'h4000_0001);
    rd_chk("wrap_with_evwr", 12'hB03, 32'd0);
    wr(12'hB80, 32'h3);
    check_all("write_vs_inc");

    for (int n = 0; n < 300; n++) begin
      events = NE'($urandom);
      retire = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        cwren = 1'b1;
        cwaddr = WR_ADDRS[$urandom_range(0, 15)];
        cwdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        if (cwaddr >= 12'h323 && cwaddr <= 12'h327) cwdata[7:0] = 8'($urandom_range(0, 10));
      end else cwren = 1'b0;
      cycle();
      check_all("rnd");
    end
    cwren = 1'b0; events = '0; retire = 1'b0;

    wr(12'h320, 32'h0);
    wr(12'h324, 32'hC000_0003);
    cycle();
    chk("irq_before_reset", {31'd0, ovf_irq}, 32'd1);
    #10;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cycle();
    rd_chk("count_after_reset", 12'hB00, 32'd3);
    check_all("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
